// File: rtl/sram_uart_dumper_pkg.sv
// Shared definitions for the SRAM-to-UART readback dumper.
package dumper_pkg;

  localparam int UART_FRAME_BITS   = 10;
  localparam int SRAM_READ_LATENCY = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT1,
    S_LATCH,
    S_SEND_HI,
    S_SEND_LO,
    S_DONE
  } dumper_state_t;

endpackage

// File: rtl/sram_uart_dumper_serializer.sv
// 8N1 UART transmitter. A start request on the last stop-bit cycle chains the
// next frame with no idle gap.
module uart_tx_serializer
  import dumper_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clock_50,
  input  logic       Reset,
  input  logic       Tx_start,
  input  logic [7:0] Tx_data,
  output logic       Tx_busy,
  output logic       Tx_done,
  output logic       UART_TX
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_BIT = 4'(UART_FRAME_BITS - 1);

  logic [CNT_W-1:0]           baud_cnt;
  logic [3:0]                 bit_idx;
  logic [UART_FRAME_BITS-1:0] shifter;

  assign Tx_done = Tx_busy && (baud_cnt == LAST_CLK) && (bit_idx == LAST_BIT);

  // shifter[0] is always the bit on the line; bit 1 is the next one out
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      Tx_busy  <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '1;
      UART_TX  <= 1'b1;
    end else if (Tx_start && (!Tx_busy || Tx_done)) begin
      Tx_busy  <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= {1'b1, Tx_data, 1'b0};
      UART_TX  <= 1'b0;
    end else if (Tx_busy) begin
      if (baud_cnt == LAST_CLK) begin
        baud_cnt <= '0;
        if (bit_idx == LAST_BIT) begin
          Tx_busy <= 1'b0;
          UART_TX <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          shifter <= {1'b1, shifter[UART_FRAME_BITS-1:1]};
          UART_TX <= shifter[1];
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_uart_dumper.sv
// Reads a contiguous SRAM region and streams each 16-bit word over UART,
// high byte first.
module sram_uart_dumper
  import dumper_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 18
) (
  input  logic              Clock_50,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Start_address,
  input  logic [ADDR_W-1:0] Word_count,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic              SRAM_we_n,
  input  logic [15:0]       SRAM_read_data,
  output logic              UART_TX,
  output logic              Busy,
  output logic              Done
);

  dumper_state_t     state;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] remaining;
  logic [7:0]        word_reg;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              tx_done;

  assign SRAM_address = addr_reg;
  assign SRAM_we_n    = 1'b1;
  assign Busy         = (state != S_IDLE) && (state != S_DONE);
  assign Done         = (state == S_DONE);

  // High byte goes straight from the read bus so its start bit lands right after LATCH;
  // only the low byte needs holding until the first frame finishes.
  assign tx_start = ((state == S_LATCH) && !tx_busy) || ((state == S_SEND_HI) && tx_done);
  assign tx_data  = (state == S_SEND_HI) ? word_reg : SRAM_read_data[15:8];

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state     <= S_IDLE;
      addr_reg  <= '0;
      remaining <= '0;
      word_reg  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (Word_count != '0) begin
              addr_reg  <= Start_address;
              remaining <= Word_count;
              state     <= S_REQ;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_REQ:   state <= S_WAIT1;
        S_WAIT1: state <= S_LATCH;
        S_LATCH: begin
          word_reg <= SRAM_read_data[7:0];
          state    <= S_SEND_HI;
        end
        S_SEND_HI: begin
          if (tx_done) state <= S_SEND_LO;
        end
        S_SEND_LO: begin
          if (tx_done) begin
            remaining <= remaining - 1'b1;
            if (remaining != ADDR_W'(1)) begin
              addr_reg <= addr_reg + 1'b1;
              state    <= S_REQ;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializer (
    .Clock_50(Clock_50),
    .Reset   (Reset),
    .Tx_start(tx_start),
    .Tx_data (tx_data),
    .Tx_busy (tx_busy),
    .Tx_done (tx_done),
    .UART_TX (UART_TX)
  );

endmodule

// File: tb/tb_sram_uart_dumper.sv
// Bench for sram_uart_dumper: SRAM model, line trace decoder and a word-level reference.
module tb_sram_uart_dumper;

  localparam int CPB      = 4;
  localparam int AW       = 18;
  localparam int MAXC     = 1024;
  localparam int FRAME    = 10 * CPB;
  localparam int WORD_CYC = 20 * CPB + 3;

  logic          clock_50 = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_address = '0;
  logic [AW-1:0] word_count = '0;
  logic [AW-1:0] sram_address;
  logic          sram_we_n;
  logic [15:0]   sram_read_data;
  logic          uart_tx;
  logic          busy;
  logic          done;

  always #5 clock_50 = ~clock_50;

  sram_uart_dumper #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (AW)
  ) dut (
    .Clock_50      (clock_50),
    .Reset         (reset),
    .Start         (start),
    .Start_address (start_address),
    .Word_count    (word_count),
    .SRAM_address  (sram_address),
    .SRAM_we_n     (sram_we_n),
    .SRAM_read_data(sram_read_data),
    .UART_TX       (uart_tx),
    .Busy          (busy),
    .Done          (done)
  );

  logic [15:0] mem [0:(1<<AW)-1];
  logic [15:0] rd_pipe;

  // Two-cycle read latency SRAM
  always @(posedge clock_50) begin
    rd_pipe        <= mem[sram_address];
    sram_read_data <= rd_pipe;
  end

  int passed = 0;
  int total  = 0;

  logic          tr_tx   [0:MAXC-1];
  logic          tr_busy [0:MAXC-1];
  logic          tr_done [0:MAXC-1];
  logic          tr_we   [0:MAXC-1];
  logic [AW-1:0] tr_addr [0:MAXC-1];
  int            n_cyc;
  int            done_at;
  bit            timed_out;
  logic [7:0]    dec_bytes[$];
  int            dec_starts[$];
  int            dec_bad;
  logic [AW-1:0] last_addr;

  // Issues one Start, then records every cycle (cycle 1 = first after sampling edge)
  task automatic capture(input logic [AW-1:0] a, input logic [AW-1:0] n,
                         input int restart_at, input int min_cycles);
    int  k;
    bit  stop;
    @(negedge clock_50);
    start = 1'b1;
    start_address = a;
    word_count = n;
    @(posedge clock_50);
    k = 0;
    done_at = 0;
    timed_out = 1'b0;
    stop = 1'b0;
    while (!stop) begin
      @(negedge clock_50);
      k++;
      start = (k == restart_at);
      if (k == restart_at) begin
        start_address = ~a;
        word_count = 18'd5;
      end
      tr_tx[k]   = uart_tx;
      tr_busy[k] = busy;
      tr_done[k] = done;
      tr_we[k]   = sram_we_n;
      tr_addr[k] = sram_address;
      if (done === 1'b1 && done_at == 0) done_at = k;
      if (done_at != 0 && k >= done_at + 1 && k >= min_cycles) stop = 1'b1;
      else if (k >= MAXC - 1) begin
        timed_out = 1'b1;
        stop = 1'b1;
      end
    end
    n_cyc = k;
    start = 1'b0;
  endtask

  task automatic decode_trace();
    int k;
    logic [7:0] b;
    dec_bytes.delete();
    dec_starts.delete();
    dec_bad = 0;
    k = 1;
    while (k <= n_cyc) begin
      if (tr_tx[k] === 1'b0 && k + FRAME - 1 <= n_cyc) begin
        if (tr_tx[k + CPB/2] !== 1'b0) dec_bad++;
        for (int i = 0; i < 8; i++) b[i] = tr_tx[k + (i + 1) * CPB + CPB/2];
        if (tr_tx[k + 9 * CPB + CPB/2] !== 1'b1) dec_bad++;
        dec_bytes.push_back(b);
        dec_starts.push_back(k);
        k += FRAME;
      end else begin
        if (tr_tx[k] !== 1'b1) dec_bad++;
        k++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock_50);
    @(negedge clock_50);
    total++; if (sram_address !== '0) $display("[TB] FAIL reset_addr: got %h expected 0", sram_address); else passed++;
    total++; if (sram_we_n !== 1'b1) $display("[TB] FAIL reset_we_n: got %b expected 1", sram_we_n); else passed++;
    total++; if (uart_tx !== 1'b1) $display("[TB] FAIL reset_tx: got %b expected 1", uart_tx); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passed++;
    reset = 1'b0;
    last_addr = '0;
  endtask

  // Full dump scenario checked against the word-level model
  task automatic test_dump_region(input string name, input logic [AW-1:0] a,
                                  input logic [AW-1:0] n, input int restart_at);
    logic [7:0]    exp_bytes[$];
    logic [7:0]    got_b;
    logic [AW-1:0] ad;
    int exp_done, exp_start, got_s, req, busy_err, done_cnt, we_low;
    for (int i = 0; i < int'(n); i++) begin
      ad = a + AW'(i);
      exp_bytes.push_back(mem[ad][15:8]);
      exp_bytes.push_back(mem[ad][7:0]);
    end
    capture(a, n, restart_at, 0);
    decode_trace();
    total++; if (timed_out) $display("[TB] FAIL %s timeout: got no Done within %0d cycles", name, MAXC); else passed++;
    total++;
    if (dec_bytes.size() != exp_bytes.size())
      $display("[TB] FAIL %s byte_count: got %0d expected %0d", name, dec_bytes.size(), exp_bytes.size());
    else passed++;
    for (int i = 0; i < exp_bytes.size(); i++) begin
      got_b = (i < dec_bytes.size()) ? dec_bytes[i] : 8'hxx;
      exp_start = 4 + (i / 2) * WORD_CYC + (i % 2) * FRAME;
      got_s = (i < dec_starts.size()) ? dec_starts[i] : -1;
      total++; if (got_b !== exp_bytes[i]) $display("[TB] FAIL %s byte[%0d]: got %h expected %h", name, i, got_b, exp_bytes[i]); else passed++;
      total++; if (got_s != exp_start) $display("[TB] FAIL %s start_cycle[%0d]: got %0d expected %0d", name, i, got_s, exp_start); else passed++;
    end
    total++; if (dec_bad != 0) $display("[TB] FAIL %s framing: got %0d bad bits expected 0", name, dec_bad); else passed++;
    for (int w = 0; w < int'(n); w++) begin
      req = 1 + w * WORD_CYC;
      ad = a + AW'(w);
      if (req < MAXC) begin
        total++; if (tr_addr[req] !== ad) $display("[TB] FAIL %s addr[%0d]: got %h expected %h", name, w, tr_addr[req], ad); else passed++;
      end
    end
    exp_done = 4 + int'(n) * 20 * CPB + (int'(n) - 1) * 3;
    busy_err = 0; done_cnt = 0; we_low = 0;
    for (int k = 1; k <= n_cyc; k++) begin
      if (tr_busy[k] !== ((k < exp_done) ? 1'b1 : 1'b0)) busy_err++;
      if (tr_done[k] === 1'b1) done_cnt++;
      if (tr_we[k] !== 1'b1) we_low++;
    end
    total++; if (done_at != exp_done) $display("[TB] FAIL %s done_cycle: got %0d expected %0d", name, done_at, exp_done); else passed++;
    total++; if (done_cnt != 1) $display("[TB] FAIL %s done_pulses: got %0d expected 1", name, done_cnt); else passed++;
    total++; if (busy_err != 0) $display("[TB] FAIL %s busy_window: got %0d wrong cycles expected 0", name, busy_err); else passed++;
    total++; if (we_low != 0) $display("[TB] FAIL %s we_n: got %0d low cycles expected 0", name, we_low); else passed++;
    last_addr = a + n - 1'b1;
  endtask

  task automatic test_single_word();
    mem[5] = 16'h41A5;
    test_dump_region("single", 18'd5, 18'd1, 0);
    total++; if (done_at != 84) $display("[TB] FAIL single done_at: got %0d expected 84", done_at); else passed++;
  endtask

  task automatic test_consecutive();
    int gap;
    mem[10] = 16'h0102;
    mem[11] = 16'h0304;
    mem[12] = 16'h0506;
    test_dump_region("consecutive", 18'd10, 18'd3, 0);
    total++; if (done_at != 250) $display("[TB] FAIL consecutive done_at: got %0d expected 250", done_at); else passed++;
    gap = 0;
    for (int k = 4 + 2 * FRAME; k < 4 + 2 * FRAME + 10 && k <= n_cyc; k++) begin
      if (tr_tx[k] !== 1'b1) break;
      gap++;
    end
    total++; if (gap != 3) $display("[TB] FAIL consecutive gap: got %0d expected 3", gap); else passed++;
  endtask

  task automatic test_zero_count();
    int busy_hi, tx_lo, addr_bad, we_low, done_cnt;
    capture(18'h1234, 18'd0, 0, 12);
    busy_hi = 0; tx_lo = 0; addr_bad = 0; we_low = 0; done_cnt = 0;
    for (int k = 1; k <= n_cyc; k++) begin
      if (tr_busy[k] !== 1'b0) busy_hi++;
      if (tr_tx[k] !== 1'b1) tx_lo++;
      if (tr_addr[k] !== last_addr) addr_bad++;
      if (tr_we[k] !== 1'b1) we_low++;
      if (tr_done[k] === 1'b1) done_cnt++;
    end
    total++; if (done_at != 1) $display("[TB] FAIL zero done_at: got %0d expected 1", done_at); else passed++;
    total++; if (done_cnt != 1) $display("[TB] FAIL zero done_pulses: got %0d expected 1", done_cnt); else passed++;
    total++; if (busy_hi != 0) $display("[TB] FAIL zero busy: got %0d high cycles expected 0", busy_hi); else passed++;
    total++; if (tx_lo != 0) $display("[TB] FAIL zero tx: got %0d non-idle cycles expected 0", tx_lo); else passed++;
    total++; if (addr_bad != 0) $display("[TB] FAIL zero addr: got %0d changed cycles expected 0", addr_bad); else passed++;
    total++; if (we_low != 0) $display("[TB] FAIL zero we_n: got %0d low cycles expected 0", we_low); else passed++;
  endtask

  task automatic test_wrap();
    mem[18'h3FFFF] = 16'hBEEF;
    mem[18'h00000] = 16'hCAFE;
    test_dump_region("wrap", 18'h3FFFF, 18'd2, 0);
  endtask

  task automatic test_back_to_back_start();
    mem[18'h2000] = 16'($urandom);
    mem[18'h2001] = 16'($urandom);
    test_dump_region("busy_start_mid_bit", 18'h2000, 18'd2, 20);
    test_dump_region("busy_start_latch", 18'h2000, 18'd2, 86);
  endtask

  task automatic test_reset_mid_transfer();
    logic [AW-1:0] a;
    mem[18'h0100] = 16'h0000;
    mem[18'h0101] = 16'hFFFF;
    @(negedge clock_50);
    start = 1'b1;
    start_address = 18'h0100;
    word_count = 18'd2;
    @(posedge clock_50);
    @(negedge clock_50);
    start = 1'b0;
    repeat (29) @(negedge clock_50);
    total++; if (uart_tx !== 1'b0) $display("[TB] FAIL pre_reset_tx: got %b expected 0", uart_tx); else passed++;
    total++; if (busy !== 1'b1) $display("[TB] FAIL pre_reset_busy: got %b expected 1", busy); else passed++;
    reset = 1'b1;
    @(posedge clock_50);
    @(negedge clock_50);
    total++; if (uart_tx !== 1'b1) $display("[TB] FAIL mid_reset_tx: got %b expected 1", uart_tx); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL mid_reset_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("[TB] FAIL mid_reset_done: got %b expected 0", done); else passed++;
    total++; if (sram_address !== '0) $display("[TB] FAIL mid_reset_addr: got %h expected 0", sram_address); else passed++;
    reset = 1'b0;
    last_addr = '0;
    a = AW'($urandom_range(0, (1 << AW) - 1));
    mem[a] = 16'($urandom);
    mem[a + 1'b1] = 16'($urandom);
    test_dump_region("after_reset", a, 18'd2, 0);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [AW-1:0] n;
    for (int r = 0; r < 6; r++) begin
      a = AW'($urandom_range(0, (1 << AW) - 1));
      n = AW'($urandom_range(1, 4));
      for (int i = 0; i < int'(n); i++) mem[a + AW'(i)] = 16'($urandom);
      test_dump_region("random", a, n, 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_consecutive();
    test_zero_count();
    test_wrap();
    test_back_to_back_start();
    test_reset_mid_transfer();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
